// File: rtl/afc_pkg.sv
// Shared types and constants for the VCO band-select calibrator.
`timescale 1ns/100ps
package afc_pkg;

   localparam int CODE_W = 6;

   // Search starts mid-scale: only the MSB set.
   localparam logic [CODE_W-1:0] RST_CODE = {1'b1, {(CODE_W-1){1'b0}}};

   typedef enum logic [1:0] {
      SETTLE,
      MEASURE,
      DECIDE,
      DONE
   } state_t;

endpackage

// File: rtl/afc_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; pulse is one clk wide.
`timescale 1ns/100ps
module afc_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic sync_p0;
   logic sync_p1;
   logic edge_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         edge_p2 <= 1'b0;
      end else begin
         sync_p0 <= din;
         sync_p1 <= sync_p0;
         edge_p2 <= sync_p1;
      end
   end

   assign pulse = sync_p1 & ~edge_p2;

endmodule

// File: rtl/afc.sv
// Automatic frequency calibrator: SAR search of the VCO band code, one bit per
// fref-vs-fdiv edge race, all counted in the fpre domain.
`timescale 1ns/100ps
module afc
   import afc_pkg::state_t;
   import afc_pkg::RST_CODE;
#(
   parameter int CODE_W = afc_pkg::CODE_W,
   parameter int WIN    = 16,
   parameter int SETTLE = 32
) (
   input  logic              fpre,
   input  logic              clr,
   input  logic              fref,
   input  logic              fdiv,
   output logic [CODE_W-1:0] out
);

   localparam int CNT_W = $clog2(WIN + 1);
   localparam int SET_W = $clog2(SETTLE);
   localparam int IDX_W = $clog2(CODE_W);

   localparam logic [CNT_W-1:0] WIN_V       = CNT_W'(WIN);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(CODE_W - 1);

   state_t            state;
   state_t            state_nxt;

   logic              ref_pulse;
   logic              div_pulse;

   logic [SET_W-1:0]  settle_cnt;
   logic [CNT_W-1:0]  ref_cnt;
   logic [CNT_W-1:0]  div_cnt;
   logic [CNT_W-1:0]  ref_cnt_nxt;
   logic [CNT_W-1:0]  div_cnt_nxt;
   logic [IDX_W-1:0]  idx;
   logic              too_fast;
   logic [CODE_W-1:0] code_nxt;

   logic              in_settle;
   logic              in_measure;
   logic              settle_done;
   logic              race_done;
   logic              decide_go;
   logic              last_bit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             hit);
      if (hit && (cnt != WIN_V)) begin
         return cnt + CNT_W'(1);
      end
      return cnt;
   endfunction

   // Input capture: fref/fdiv enter the fpre domain here
   afc_edge_sync u_ref_sync (
      .clk   (fpre),
      .rst_n (clr),
      .din   (fref),
      .pulse (ref_pulse)
   );

   afc_edge_sync u_div_sync (
      .clk   (fpre),
      .rst_n (clr),
      .din   (fdiv),
      .pulse (div_pulse)
   );

   assign ref_cnt_nxt = sat_inc(ref_cnt, ref_pulse);
   assign div_cnt_nxt = sat_inc(div_cnt, div_pulse);
   assign last_bit    = (idx == '0);

   // Control: state register
   always_ff @(posedge fpre or negedge clr) begin
      if (!clr) begin
         state <= afc_pkg::SETTLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         afc_pkg::SETTLE:  if (settle_done) state_nxt = afc_pkg::MEASURE;
         afc_pkg::MEASURE: if (race_done)   state_nxt = afc_pkg::DECIDE;
         afc_pkg::DECIDE:  state_nxt = last_bit ? afc_pkg::DONE : afc_pkg::SETTLE;
         afc_pkg::DONE:    state_nxt = state;
      endcase
   end

   always_comb begin
      in_settle  = 1'b0;
      in_measure = 1'b0;
      decide_go  = 1'b0;
      unique case (state)
         afc_pkg::SETTLE:  in_settle  = 1'b1;
         afc_pkg::MEASURE: in_measure = 1'b1;
         afc_pkg::DECIDE:  decide_go  = 1'b1;
         afc_pkg::DONE:    ;
      endcase
      settle_done = in_settle && (settle_cnt == SETTLE_LAST);
      race_done   = in_measure && ((ref_cnt_nxt == WIN_V) || (div_cnt_nxt == WIN_V));
   end

   // Trial resolution: drop the bit under test if the VCO ran fast, arm the next one
   always_comb begin
      code_nxt = out;
      if (too_fast) begin
         code_nxt[idx] = 1'b0;
      end
      if (!last_bit) begin
         code_nxt[idx - IDX_W'(1)] = 1'b1;
      end
   end

   // Measurement counters and the registered code
   always_ff @(posedge fpre or negedge clr) begin
      if (!clr) begin
         settle_cnt <= '0;
         ref_cnt    <= '0;
         div_cnt    <= '0;
         too_fast   <= 1'b0;
         idx        <= IDX_TOP;
         out        <= RST_CODE;
      end else begin
         if (in_settle) begin
            settle_cnt <= settle_done ? '0 : settle_cnt + SET_W'(1);
         end

         if (settle_done) begin
            ref_cnt <= '0;
            div_cnt <= '0;
         end else if (in_measure) begin
            ref_cnt <= ref_cnt_nxt;
            div_cnt <= div_cnt_nxt;
         end

         // A same-cycle finish counts as not fast.
         if (race_done) begin
            too_fast <= (div_cnt_nxt == WIN_V) && (ref_cnt_nxt != WIN_V);
         end

         if (decide_go) begin
            out <= code_nxt;
            if (!last_bit) begin
               idx <= idx - IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_afc.sv
// Self-checking bench for afc: fixed-ratio and behavioural-VCO clock sources,
// SAR outcome predicted from frequency ratios alone.
`timescale 1ns/100ps
module tb_afc;

   localparam int CW = 6;
   localparam logic [CW-1:0] MID = 6'b100000;

   logic          fpre;
   logic          clr;
   logic          fref;
   logic          fdiv;
   logic [CW-1:0] out;

   int  vectors     = 0;
   int  miscompares = 0;

   real ref_per  = 400.0;
   real div_per  = 200.0;
   real t0       = 0.0;
   bit  osc_en   = 1'b0;
   bit  vco_mode = 1'b0;
   int  vco_k    = 37;

   logic [CW-1:0] obs[$];

   afc #(.CODE_W(CW), .WIN(16), .SETTLE(32)) dut (
      .fpre (fpre),
      .clr  (clr),
      .fref (fref),
      .fdiv (fdiv),
      .out  (out)
   );

   initial begin
      fpre = 1'b0;
      forever #5 fpre = ~fpre;
   end

   function automatic bit phase_hi(input real t, input real p);
      real m;
      if (t < 0.0 || p <= 0.0) return 1'b0;
      m = t - p * $floor(t / p);
      return m < (p / 2.0);
   endfunction

   // Oscillators evaluated on a 1 ns grid offset from the fpre edges.
   initial begin
      fref = 1'b0;
      fdiv = 1'b0;
      #0.5;
      forever begin
         #1;
         fref = osc_en & phase_hi($realtime - t0, ref_per);
         fdiv = osc_en & phase_hi($realtime - t0, div_per);
      end
   end

   task automatic restart_vco();
      div_per = (out == '0) ? 0.0 : ref_per * real'(vco_k) / real'(int'(out));
      t0      = $realtime + 1000.0;
   endtask

   always @(out) begin
      obs.push_back(out);
      if (vco_mode) restart_vco();
   end

   function automatic bit is_fast(input int code, input bit tie_fast);
      if (!vco_mode) return (1.0 / div_per) > (1.0 / ref_per);
      if (code == vco_k) return tie_fast;
      return code > vco_k;
   endfunction

   // Binary search on the code: keep a bit only if the VCO was not too fast.
   task automatic sar_model(input bit tie_fast, output logic [CW-1:0] seq[5],
                            output logic [CW-1:0] fin);
      int code;
      code = 1 << (CW - 1);
      for (int b = CW - 1; b >= 0; b--) begin
         if (is_fast(code, tie_fast)) code = code - (1 << b);
         if (b > 0) begin
            code = code + (1 << (b - 1));
            seq[CW - 1 - b] = CW'(code);
         end
      end
      fin = CW'(code);
   endtask

   task automatic check(input string tag, input logic [CW-1:0] got,
                        input logic [CW-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_any(input string tag, input logic [CW-1:0] got,
                            input logic [CW-1:0] exp_a, input logic [CW-1:0] exp_b);
      vectors++;
      assert (got === exp_a || got === exp_b) else begin
         miscompares++;
         $error("FAIL %s: got %b expected %b or %b", tag, got, exp_a, exp_b);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      vectors++;
      assert (got == exp) else begin
         miscompares++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse_reset();
      @(posedge fpre);
      #2;
      clr = 1'b0;
      #1;
      check("async_reset", out, MID);
      #19;
      clr = 1'b1;
      obs.delete();
   endtask

   task automatic run_and_check(input string tag, input int budget);
      logic [CW-1:0] seq_a[5];
      logic [CW-1:0] seq_b[5];
      logic [CW-1:0] fin_a;
      logic [CW-1:0] fin_b;
      logic [CW-1:0] got;
      repeat (budget) @(negedge fpre);
      sar_model(1'b0, seq_a, fin_a);
      sar_model(1'b1, seq_b, fin_b);
      for (int i = 0; i < 5; i++) begin
         got = (i < obs.size()) ? obs[i] : {CW{1'bx}};
         check_any($sformatf("%s_step%0d", tag, i + 1), got, seq_a[i], seq_b[i]);
      end
      check_any({tag, "_final"}, out, fin_a, fin_b);
   endtask

   initial begin
      logic [CW-1:0] held;
      clr = 1'b0;

      // Fixed sources, fdiv at twice fref: every trial too fast.
      vco_mode = 1'b0;
      ref_per  = 400.0;
      div_per  = 200.0;
      osc_en   = 1'b1;
      repeat (3) @(negedge fpre);
      check("reset_state", out, MID);
      @(posedge fpre);
      #2;
      clr = 1'b1;
      obs.delete();
      run_and_check("fast", 5000);
      check("fast_abs", out, 6'b000000);

      // fdiv at half fref: never too fast.
      div_per = 800.0;
      pulse_reset();
      run_and_check("slow", 5000);
      check("slow_abs", out, 6'b111111);

      // Behavioural VCO, target 37, reset pulsed during the third trial.
      vco_mode = 1'b1;
      vco_k    = 37;
      pulse_reset();
      for (int i = 0; i < 3000 && obs.size() < 2; i++) @(negedge fpre);
      check_int("reach_trial3", int'(obs.size() >= 2), 1);
      repeat (100) @(negedge fpre);
      pulse_reset();
      run_and_check("vco37", 5000);

      // After DONE a new VCO curve must not move the code until clr.
      held  = out;
      obs.delete();
      vco_k = 21;
      restart_vco();
      repeat (3000) @(negedge fpre);
      check("done_hold", out, held);
      check_int("done_no_change", obs.size(), 0);
      pulse_reset();
      run_and_check("vco21", 5000);

      // Sources stopped: search stalls at the reset code, then resumes.
      osc_en   = 1'b0;
      vco_mode = 1'b0;
      div_per  = 200.0;
      pulse_reset();
      repeat (3000) @(negedge fpre);
      check("stall_code", out, MID);
      check_int("stall_no_change", obs.size(), 0);
      t0     = $realtime;
      osc_en = 1'b1;
      run_and_check("resume", 5000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/afc.md
Name: afc

Overview:
- Automatic frequency calibrator for the PLL VCO band select.
- Runs a 6-bit successive-approximation (SAR) search on the VCO capacitor-bank code `out`.
- Each trial races the divided VCO clock `fdiv` against the reference `fref`, both counted in the `fpre` (prescaler) clock domain.
- After 6 trials it holds the final code until the next reset.

Parameters:
- CODE_W, 6, width of the band-select code `out`.
- WIN, 16, number of rising edges of `fref` or `fdiv` that ends a measurement race.
- SETTLE, 32, number of `fpre` cycles to wait after each code change before measuring.

Ports:
- fpre  input  1  sole clock; all state updates on its rising edge.
- clr  input  1  reset, asynchronous, active-low.
- fref  input  1  reference clock, treated as async data; synchronized internally.
- fdiv  input  1  divided VCO clock, treated as async data; synchronized internally.
- out  output  CODE_W  band-select code to the VCO. Registered. Higher code gives higher VCO frequency.

Behaviour:
- Reset (clr=0, asynchronous):
  - out=6'b100000, bit index idx=5, state=SETTLE.
  - All counters and synchronizer flops cleared.
- Input synchronization:
  - fref and fdiv each pass through a 2-flop synchronizer plus one edge register.
  - A rising-edge pulse is 1 fpre cycle wide and lags the input edge by 2-3 cycles.
  - Input high/low phases must each be at least 2 fpre periods.
- SETTLE:
  - Count fpre cycles. When the count reaches SETTLE-1, clear ref_cnt and div_cnt and go to MEASURE.
- MEASURE:
  - ref_cnt increments on each fref edge pulse; div_cnt increments on each fdiv edge pulse. Both saturate at WIN.
  - When either count reaches WIN, latch too_fast = (div_cnt reached WIN while ref_cnt < WIN), then go to DECIDE.
  - If both reach WIN in the same cycle, too_fast=0.
- DECIDE (one cycle):
  - If too_fast, clear out[idx].
  - If idx>0: set out[idx-1]=1, decrement idx, go to SETTLE.
  - If idx==0: go to DONE.
  - out changes only on the DECIDE edge.
- DONE:
  - Terminal state; out holds its value and edge pulses are ignored.
  - Recalibration only via clr.
- No timeout: if fref or fdiv stops, the block waits in MEASURE indefinitely with out held.
- Reset mid-operation: out returns to 100000 immediately, and the search restarts from idx=5 after clr deasserts.
- Total calibration time: 6 × (SETTLE + measurement + 1) fpre cycles.
- Counter width is clog2(WIN+1). The SETTLE counter width is clog2(SETTLE).

Decomposition:
- Shared package `afc_pkg`:
  - state enum {SETTLE, MEASURE, DECIDE, DONE}
  - CODE_W
  - reset code constant RST_CODE = 6'b100000
- One sub-module, `afc_edge_sync`:
  - 2-flop synchronizer plus rising-edge detector, with the same async active-low reset.
  - Instantiated twice, for fref and fdiv.

Test Plan:
- fdiv always 2× fref frequency, fpre period 10 ns, fref period 400 ns → each trial too_fast. Code sequence 100000, 010000, 001000, 000100, 000010, 000001; final out=000000.
- fdiv at half the fref frequency → never too_fast. Code sequence 100000, 110000, 111000, 111100, 111110, 111111; final out=111111.
- Behavioural VCO model with fdiv frequency = fref × code/37 → final out=37 (100101). Allow 36 or 37 only when the model puts the race at a tie.
- Pulse clr low for 20 ns during the third trial → out=100000 within the same ns with no clock edge, then a full 6-trial search completes to the same final value.
- Stop fdiv and fref after reset → out stays 100000 indefinitely and never reaches DONE. Restarting the clocks resumes the search normally.
- After DONE, change the fdiv frequency → out unchanged until clr is toggled, after which recalibration converges to the new code.
